l2_arbiter: RTL and testbench



---
 rtl/l2_arbiter_if.sv | 42 ++++
 rtl/l2_arbiter.sv | 96 +++++++++
 tb/tb_l2_arbiter.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/l2_arbiter_if.sv
// rtl/l2_arbiter_if.sv - I-cache, D-cache and L2 line buses seen by the L2 arbiter
interface l2_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int LINE_W = 128
);
  logic              icache_read;
  logic [ADDR_W-1:0] icache_address;
  logic [LINE_W-1:0] icache_rdata;
  logic              icache_resp;

  logic              dcache_read;
  logic              dcache_write;
  logic [ADDR_W-1:0] dcache_address;
  logic [LINE_W-1:0] dcache_wdata;
  logic [LINE_W-1:0] dcache_rdata;
  logic              dcache_resp;

  logic              l2_read;
  logic              l2_write;
  logic [ADDR_W-1:0] l2_address;
  logic [LINE_W-1:0] l2_wdata;
  logic [LINE_W-1:0] l2_rdata;
  logic              l2_resp;

  modport slave (
    input  icache_read, icache_address,
    output icache_rdata, icache_resp,
    input  dcache_read, dcache_write, dcache_address, dcache_wdata,
    output dcache_rdata, dcache_resp,
    output l2_read, l2_write, l2_address, l2_wdata,
    input  l2_rdata, l2_resp
  );

  modport master (
    output icache_read, icache_address,
    input  icache_rdata, icache_resp,
    output dcache_read, dcache_write, dcache_address, dcache_wdata,
    input  dcache_rdata, dcache_resp,
    input  l2_read, l2_write, l2_address, l2_wdata,
    output l2_rdata, l2_resp
  );
endinterface

// File: rtl/l2_arbiter.sv
// rtl/l2_arbiter.sv - serializes I-cache and D-cache line requests onto one L2 port
// Contention policy: D-side fixed priority, or round robin when L2_ARB_ROUND_ROBIN_EN is defined.
module l2_arbiter #(
  parameter int ADDR_W = 16,
  parameter int LINE_W = 128
) (
  input logic       clk,
  input logic       rst_n,
  l2_arbiter_if.slave bus
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] BUSY_I = 2'd1;
  localparam logic [1:0] BUSY_D = 2'd2;

  logic [1:0]        state;
  logic              read_q;
  logic              write_q;
  logic [ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0] wdata_q;

  logic i_req;
  logic d_req;
  logic grant_d;

  assign i_req = bus.icache_read;
  assign d_req = bus.dcache_read | bus.dcache_write;

`ifdef L2_ARB_ROUND_ROBIN_EN
  // Set when the most recent grant went to the D-side; resets to the I-side.
  logic last_d;

  assign grant_d = d_req & (~i_req | ~last_d);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_d <= 1'b0;
    end else if (state == IDLE && (i_req || d_req)) begin
      last_d <= grant_d;
    end
  end
`else
  assign grant_d = d_req;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      read_q  <= 1'b0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_d) begin
            // A simultaneous read+write from the D-side is treated as a writeback.
            state   <= BUSY_D;
            write_q <= bus.dcache_write;
            read_q  <= ~bus.dcache_write;
            addr_q  <= bus.dcache_address;
            wdata_q <= bus.dcache_wdata;
          end else if (i_req) begin
            state   <= BUSY_I;
            read_q  <= 1'b1;
            write_q <= 1'b0;
            addr_q  <= bus.icache_address;
          end
        end
        BUSY_I, BUSY_D: begin
          if (bus.l2_resp) begin
            state   <= IDLE;
            read_q  <= 1'b0;
            write_q <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          read_q  <= 1'b0;
          write_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.l2_read    = read_q;
  assign bus.l2_write   = write_q;
  assign bus.l2_address = addr_q;
  assign bus.l2_wdata   = wdata_q;

  assign bus.icache_resp  = (state == BUSY_I) & bus.l2_resp;
  assign bus.dcache_resp  = (state == BUSY_D) & bus.l2_resp;
  assign bus.icache_rdata = bus.l2_rdata;
  assign bus.dcache_rdata = bus.l2_rdata;

endmodule

// File: tb/tb_l2_arbiter.sv
// tb/tb_l2_arbiter.sv - scoreboard bench for l2_arbiter, L2 modelled by the bench tasks
module tb_l2_arbiter;
  localparam int AW = 16;
  localparam int LW = 128;

`ifdef L2_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  l2_arbiter_if #(.ADDR_W(AW), .LINE_W(LW)) bus ();
  l2_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    logic          side_d;
    logic [AW-1:0] addr;
    logic [LW-1:0] data;
  } exp_t;

  exp_t sb[$];
  int passed = 0;
  int total  = 0;

  function automatic exp_t mk(input logic side_d, input logic [AW-1:0] addr, input logic [LW-1:0] data);
    exp_t e;
    e.side_d = side_d;
    e.addr   = addr;
    e.data   = data;
    return e;
  endfunction

  // Bounded wait for an L2 request; cyc counts negedges from the call.
  task automatic wait_l2_req(output int cyc, output bit ok);
    cyc = 0;
    ok  = 1'b0;
    for (int i = 1; i <= 20 && !ok; i++) begin
      @(negedge clk);
      if (bus.l2_read || bus.l2_write) begin
        ok  = 1'b1;
        cyc = i;
      end
    end
  endtask

  // L2 model: answer after delay cycles, record responses, drop the served request.
  task automatic l2_service(input int delay, input logic [LW-1:0] data,
                            output bit seen_i, output bit seen_d,
                            output logic [LW-1:0] rd, output bit post_rw);
    repeat (delay) @(negedge clk);
    bus.l2_resp  = 1'b1;
    bus.l2_rdata = data;
    #1;
    seen_i = bus.icache_resp;
    seen_d = bus.dcache_resp;
    rd     = seen_d ? bus.dcache_rdata : bus.icache_rdata;
    if (seen_i) bus.icache_read = 1'b0;
    if (seen_d) begin
      bus.dcache_read  = 1'b0;
      bus.dcache_write = 1'b0;
    end
    @(negedge clk);
    bus.l2_resp = 1'b0;
    post_rw = bus.l2_read | bus.l2_write;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    bus.icache_read = 1'b0; bus.icache_address = '0;
    bus.dcache_read = 1'b0; bus.dcache_write = 1'b0;
    bus.dcache_address = '0; bus.dcache_wdata = '0;
    bus.l2_resp = 1'b0; bus.l2_rdata = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (bus.l2_read !== 1'b0) $display("FAIL reset_l2_read got=%b want=0", bus.l2_read); else passed++;
    total++; if (bus.l2_write !== 1'b0) $display("FAIL reset_l2_write got=%b want=0", bus.l2_write); else passed++;
    total++; if (bus.l2_address !== '0) $display("FAIL reset_l2_address got=%h want=0", bus.l2_address); else passed++;
    total++; if (bus.l2_wdata !== '0) $display("FAIL reset_l2_wdata got=%h want=0", bus.l2_wdata); else passed++;
    total++; if ({bus.icache_resp, bus.dcache_resp} !== 2'b00)
      $display("FAIL reset_resp got=%b%b want=00", bus.icache_resp, bus.dcache_resp); else passed++;
  endtask

  task automatic test_icache_read;
    exp_t e; int cyc; bit ok, si, sd, prw; logic [LW-1:0] rd;
    @(negedge clk);
    bus.icache_read = 1'b1; bus.icache_address = 16'h1230;
    sb.push_back(mk(1'b0, 16'h1230, {16{8'hA5}}));
    wait_l2_req(cyc, ok);
    total++; if (!ok || cyc != 1) $display("FAIL i_latency got=%0d want=1", cyc); else passed++;
    total++; if ({bus.l2_read, bus.l2_write} !== 2'b10)
      $display("FAIL i_op got=%b%b want=10", bus.l2_read, bus.l2_write); else passed++;
    total++; if (bus.l2_address !== sb[0].addr)
      $display("FAIL i_address got=%h want=%h", bus.l2_address, sb[0].addr); else passed++;
    l2_service(3, sb[0].data, si, sd, rd, prw);
    e = sb.pop_front();
    total++; if ({si, sd} !== {~e.side_d, e.side_d} || rd !== e.data)
      $display("FAIL i_resp got=%b%b/%h want=%b%b/%h", si, sd, rd, ~e.side_d, e.side_d, e.data); else passed++;
    total++; if (prw !== 1'b0) $display("FAIL i_release got=%b want=0", prw); else passed++;
  endtask

  task automatic test_dcache_write;
    exp_t e; int cyc; bit ok, si, sd, prw; logic [LW-1:0] rd;
    @(negedge clk);
    bus.dcache_write = 1'b1; bus.dcache_address = 16'h4000; bus.dcache_wdata = {8{16'h1111}};
    sb.push_back(mk(1'b1, 16'h4000, {4{32'h0BAD_F00D}}));
    wait_l2_req(cyc, ok);
    total++; if (!ok || {bus.l2_read, bus.l2_write} !== 2'b01)
      $display("FAIL d_op got=%b%b want=01", bus.l2_read, bus.l2_write); else passed++;
    bus.dcache_wdata = {8{16'h2222}}; bus.dcache_address = 16'h4444;
    @(negedge clk);
    total++; if (bus.l2_wdata !== {8{16'h1111}} || bus.l2_address !== sb[0].addr)
      $display("FAIL d_hold got=%h/%h want=%h/%h", bus.l2_address, bus.l2_wdata, sb[0].addr, {8{16'h1111}}); else passed++;
    l2_service(2, sb[0].data, si, sd, rd, prw);
    e = sb.pop_front();
    total++; if ({si, sd} !== {~e.side_d, e.side_d} || rd !== e.data)
      $display("FAIL d_resp got=%b%b/%h want=%b%b/%h", si, sd, rd, ~e.side_d, e.side_d, e.data); else passed++;
    #1;
    total++; if ({prw, bus.dcache_resp} !== 2'b00)
      $display("FAIL d_single_pulse got=%b%b want=00", prw, bus.dcache_resp); else passed++;
  endtask

  task automatic test_both_rw;
    exp_t e; int cyc; bit ok, si, sd, prw; logic [LW-1:0] rd;
    @(negedge clk);
    bus.dcache_read = 1'b1; bus.dcache_write = 1'b1;
    bus.dcache_address = 16'h5550; bus.dcache_wdata = {4{32'hCAFE_F00D}};
    sb.push_back(mk(1'b1, 16'h5550, {4{32'h5A5A_0F0F}}));
    wait_l2_req(cyc, ok);
    total++; if (!ok || {bus.l2_read, bus.l2_write} !== 2'b01 || bus.l2_address !== sb[0].addr)
      $display("FAIL rw_write_wins got=%b%b/%h want=01/%h", bus.l2_read, bus.l2_write, bus.l2_address, sb[0].addr); else passed++;
    l2_service(1, sb[0].data, si, sd, rd, prw);
    e = sb.pop_front();
    total++; if ({si, sd} !== {~e.side_d, e.side_d} || rd !== e.data || prw !== 1'b0)
      $display("FAIL rw_resp got=%b%b/%h want=%b%b/%h", si, sd, rd, ~e.side_d, e.side_d, e.data); else passed++;
  endtask

  task automatic test_reset_busy;
    exp_t e; int cyc; bit ok, si, sd, prw; logic [LW-1:0] rd;
    @(negedge clk);
    bus.icache_read = 1'b1; bus.icache_address = 16'h7770;
    sb.push_back(mk(1'b0, 16'h7770, '1));
    wait_l2_req(cyc, ok);
    total++; if (!ok || bus.l2_read !== 1'b1) $display("FAIL rb_grant got=%b want=1", bus.l2_read); else passed++;
    @(negedge clk);
    rst_n = 1'b0; bus.l2_resp = 1'b1; bus.l2_rdata = '1;
    #1;
    total++; if ({bus.l2_read, bus.l2_write, bus.icache_resp, bus.dcache_resp} !== 4'b0000)
      $display("FAIL rb_async_ctl got=%b%b%b%b want=0000", bus.l2_read, bus.l2_write, bus.icache_resp, bus.dcache_resp); else passed++;
    total++; if (bus.l2_address !== '0 || bus.l2_wdata !== '0)
      $display("FAIL rb_async_data got=%h/%h want=0/0", bus.l2_address, bus.l2_wdata); else passed++;
    void'(sb.pop_front());
    @(negedge clk);
    bus.l2_resp = 1'b0; bus.icache_read = 1'b0; rst_n = 1'b1;
    @(negedge clk);
    total++; if ({bus.l2_read, bus.l2_write} !== 2'b00)
      $display("FAIL rb_idle_after got=%b%b want=00", bus.l2_read, bus.l2_write); else passed++;
    bus.icache_read = 1'b1; bus.icache_address = 16'h0880;
    sb.push_back(mk(1'b0, 16'h0880, {4{32'h0880_0880}}));
    wait_l2_req(cyc, ok);
    total++; if (!ok || cyc != 1 || bus.l2_read !== 1'b1 || bus.l2_address !== sb[0].addr)
      $display("FAIL rb_regrant got=%0d/%b/%h want=1/1/%h", cyc, bus.l2_read, bus.l2_address, sb[0].addr); else passed++;
    l2_service(2, sb[0].data, si, sd, rd, prw);
    e = sb.pop_front();
    total++; if ({si, sd} !== {~e.side_d, e.side_d} || rd !== e.data)
      $display("FAIL rb_resp got=%b%b/%h want=%b%b/%h", si, sd, rd, ~e.side_d, e.side_d, e.data); else passed++;
  endtask

  task automatic test_spurious_resp;
    exp_t e; int cyc; bit ok, si, sd, prw; logic [LW-1:0] rd;
    @(negedge clk);
    bus.l2_resp = 1'b1; bus.l2_rdata = {4{32'hDEAD_BEEF}};
    #1;
    total++; if ({bus.icache_resp, bus.dcache_resp} !== 2'b00)
      $display("FAIL sp_resp got=%b%b want=00", bus.icache_resp, bus.dcache_resp); else passed++;
    @(negedge clk);
    bus.l2_resp = 1'b0;
    total++; if ({bus.l2_read, bus.l2_write} !== 2'b00)
      $display("FAIL sp_state got=%b%b want=00", bus.l2_read, bus.l2_write); else passed++;
    bus.icache_read = 1'b1; bus.icache_address = 16'h0ABC;
    sb.push_back(mk(1'b0, 16'h0ABC, {4{32'h1234_5678}}));
    wait_l2_req(cyc, ok);
    total++; if (!ok || cyc != 1 || bus.l2_address !== sb[0].addr)
      $display("FAIL sp_next_grant got=%0d/%h want=1/%h", cyc, bus.l2_address, sb[0].addr); else passed++;
    l2_service(1, sb[0].data, si, sd, rd, prw);
    e = sb.pop_front();
    total++; if ({si, sd} !== {~e.side_d, e.side_d} || rd !== e.data)
      $display("FAIL sp_after_resp got=%b%b/%h want=%b%b/%h", si, sd, rd, ~e.side_d, e.side_d, e.data); else passed++;
  endtask

  task automatic test_contention;
    exp_t e; int cyc; bit ok, si, sd, prw; logic [LW-1:0] rd;
    // Round 1: last grant is I, so D wins in both builds; I follows two cycles after D's resp.
    @(negedge clk);
    bus.icache_read = 1'b1; bus.icache_address = 16'h1000;
    bus.dcache_read = 1'b1; bus.dcache_address = 16'h2000;
    sb.push_back(mk(1'b1, 16'h2000, {4{32'hD0D0_0001}}));
    sb.push_back(mk(1'b0, 16'h1000, {4{32'h1111_0001}}));
    prw = 1'b0;
    for (int k = 0; k < 2; k++) begin
      wait_l2_req(cyc, ok);
      total++; if (!ok || bus.l2_address !== sb[0].addr || {bus.l2_read, bus.l2_write} !== 2'b10)
        $display("FAIL c1_grant%0d got=%h/%b%b want=%h/10", k, bus.l2_address, bus.l2_read, bus.l2_write, sb[0].addr); else passed++;
      if (k == 1) begin
        total++; if (cyc != 1 || prw !== 1'b0)
          $display("FAIL c1_gap got=%0d/%b want=1/0", cyc, prw); else passed++;
      end
      l2_service(2, sb[0].data, si, sd, rd, prw);
      e = sb.pop_front();
      total++; if ({si, sd} !== {~e.side_d, e.side_d} || rd !== e.data)
        $display("FAIL c1_resp%0d got=%b%b/%h want=%b%b/%h", k, si, sd, rd, ~e.side_d, e.side_d, e.data); else passed++;
    end
    // Round 2: D wins again, then re-requests while I waits; round robin hands the next grant to I.
    @(negedge clk);
    bus.icache_read = 1'b1; bus.icache_address = 16'h1100;
    bus.dcache_read = 1'b1; bus.dcache_address = 16'h2100;
    sb.push_back(mk(1'b1, 16'h2100, {4{32'hD0D0_0002}}));
    if (RR) begin
      sb.push_back(mk(1'b0, 16'h1100, {4{32'h1111_0002}}));
      sb.push_back(mk(1'b1, 16'h2200, {4{32'hD0D0_0003}}));
    end else begin
      sb.push_back(mk(1'b1, 16'h2200, {4{32'hD0D0_0003}}));
      sb.push_back(mk(1'b0, 16'h1100, {4{32'h1111_0002}}));
    end
    for (int k = 0; k < 3; k++) begin
      wait_l2_req(cyc, ok);
      total++; if (!ok || bus.l2_address !== sb[0].addr)
        $display("FAIL c2_grant%0d got=%h want=%h", k, bus.l2_address, sb[0].addr); else passed++;
      l2_service(1, sb[0].data, si, sd, rd, prw);
      e = sb.pop_front();
      total++; if ({si, sd} !== {~e.side_d, e.side_d} || rd !== e.data)
        $display("FAIL c2_resp%0d got=%b%b/%h want=%b%b/%h", k, si, sd, rd, ~e.side_d, e.side_d, e.data); else passed++;
      if (k == 0) begin
        bus.dcache_read = 1'b1; bus.dcache_address = 16'h2200;
      end
    end
    total++; if (sb.size() != 0) $display("FAIL sb_drained got=%0d want=0", sb.size()); else passed++;
  endtask

  initial begin
    test_reset;
    test_icache_read;
    test_dcache_write;
    test_both_rw;
    test_reset_busy;
    test_spurious_resp;
    test_contention;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end
endmodule
